// File: rtl/adc_scan_sequencer.sv
// Periodic multi-channel ADC scan engine: issues MCP3008 commands through a 24-bit SPI controller
// and buffers tagged 10-bit samples in a FWFT FIFO. Optional response watchdog: ADC_SEQ_TIMEOUT_EN.
module adc_scan_sequencer #(
    parameter int unsigned NUM_CHANNELS         = 8,
    parameter int unsigned SAMPLE_PERIOD_CYCLES = 100000,
    parameter int unsigned FIFO_DEPTH           = 8,
    parameter int unsigned TIMEOUT_CYCLES       = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_CHANNELS-1:0] channel_mask,
    input  logic                    clear_flags,
    output logic                    cmd_valid,
    output logic [23:0]             cmd_data,
    input  logic                    cmd_ready,
    input  logic                    rsp_valid,
    input  logic [23:0]             rsp_data,
    output logic                    m_valid,
    output logic [9:0]              m_data,
    output logic [2:0]              m_channel,
    input  logic                    m_ready,
    output logic                    busy,
    output logic                    fifo_overflow,
    output logic                    scan_overrun,
    output logic                    rsp_timeout
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_PERIOD_CYCLES);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam logic [23:0] CMD_BASE = 24'h018000;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RSP, S_NEXT} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        period_cnt;
    logic                    tick;
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [NUM_CHANNELS-1:0] remaining;
    logic [2:0]              cur_ch;
    logic                    cap_valid;
    logic [9:0]              cap_data;
    logic [2:0]              cap_ch;

    function automatic logic [2:0] lowest(input logic [NUM_CHANNELS-1:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Scan period timebase; held at zero while disabled
    assign tick = enable && (period_cnt == CNT_W'(SAMPLE_PERIOD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !enable) period_cnt <= '0;
        else if (tick)      period_cnt <= '0;
        else                period_cnt <= period_cnt + CNT_W'(1);
    end

    assign remaining = mask_q & ~(NUM_CHANNELS'(1) << cur_ch);

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wd_cnt;
    logic            unused_bits;
    assign unused_bits = ^rsp_data[23:10];
`else
    logic unused_bits;
    assign unused_bits = ^{rsp_data[23:10], 32'(TIMEOUT_CYCLES)};
    assign rsp_timeout = 1'b0;
`endif

    // Scan sequencer; cmd_valid and the capture strobe are single-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            mask_q       <= '0;
            cur_ch       <= '0;
            cmd_valid    <= 1'b0;
            cmd_data     <= '0;
            busy         <= 1'b0;
            cap_valid    <= 1'b0;
            cap_data     <= '0;
            cap_ch       <= '0;
            scan_overrun <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
            wd_cnt       <= '0;
            rsp_timeout  <= 1'b0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            cap_valid <= 1'b0;
            if (clear_flags)                scan_overrun <= 1'b0;
            if (tick && state != S_IDLE)    scan_overrun <= 1'b1;
`ifdef ADC_SEQ_TIMEOUT_EN
            if (clear_flags)                rsp_timeout <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (tick && |channel_mask) begin
                        mask_q <= channel_mask;
                        cur_ch <= lowest(channel_mask);
                        busy   <= 1'b1;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b1;
                        cmd_data  <= CMD_BASE | (24'(cur_ch) << 12);
                        state     <= S_WAIT_RSP;
`ifdef ADC_SEQ_TIMEOUT_EN
                        wd_cnt    <= '0;
`endif
                    end
                end
                S_WAIT_RSP: begin
                    if (rsp_valid) begin
                        cap_valid <= 1'b1;
                        cap_data  <= rsp_data[9:0];
                        cap_ch    <= cur_ch;
                        state     <= S_NEXT;
                    end
`ifdef ADC_SEQ_TIMEOUT_EN
                    else if (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        cap_valid   <= 1'b1;
                        cap_data    <= 10'h3FF;
                        cap_ch      <= cur_ch;
                        rsp_timeout <= 1'b1;
                        state       <= S_NEXT;
                    end else begin
                        wd_cnt <= wd_cnt + TO_W'(1);
                    end
`endif
                end
                S_NEXT: begin
                    mask_q <= remaining;
                    if (|remaining) begin
                        cur_ch <= lowest(remaining);
                        state  <= S_ISSUE;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sample FIFO, first-word-fall-through, extra pointer bit distinguishes full from empty
    logic [9:0]    mem_data [FIFO_DEPTH];
    logic [2:0]    mem_ch   [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          push;

    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop  = m_valid && m_ready;
    assign push = cap_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (clear_flags)         fifo_overflow <= 1'b0;
            if (cap_valid && !push)  fifo_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]] <= cap_data;
            mem_ch[wr_ptr[AW-1:0]]   <= cap_ch;
        end
    end

    assign m_valid   = (wr_ptr != rd_ptr);
    assign m_data    = m_valid ? mem_data[rd_ptr[AW-1:0]] : '0;
    assign m_channel = m_valid ? mem_ch[rd_ptr[AW-1:0]]   : '0;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: responder/consumer processes against a queue model of scan order
// and FIFO contents; directed steps for overrun, overflow, stall, reset and (with macro) timeout.
module tb_adc_scan_sequencer;

    localparam int unsigned P = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  channel_mask;
    logic        clear_flags;
    logic        cmd_valid;
    logic [23:0] cmd_data;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [23:0] rsp_data;
    logic        m_valid;
    logic [9:0]  m_data;
    logic [2:0]  m_channel;
    logic        m_ready;
    logic        busy;
    logic        fifo_overflow;
    logic        scan_overrun;
    logic        rsp_timeout;

    always #5 clk = ~clk;

    adc_scan_sequencer #(
        .NUM_CHANNELS(8), .SAMPLE_PERIOD_CYCLES(P), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .channel_mask(channel_mask),
        .clear_flags(clear_flags), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .m_valid(m_valid), .m_data(m_data), .m_channel(m_channel), .m_ready(m_ready),
        .busy(busy), .fifo_overflow(fifo_overflow), .scan_overrun(scan_overrun),
        .rsp_timeout(rsp_timeout)
    );

    int          errors = 0;
    int          checks = 0;
    int          exp_ch[$];
    logic [23:0] force_q[$];
    logic [12:0] exp_fifo[$];
    int          rsp_delay = 0;
    int          silent_ch = -1;
    bit          hold = 1'b0;
    int          ready_mode = 1;
    bit          stray_req = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [23:0] cmd_word(input int c);
        return 24'h018000 | (24'(c) << 12);
    endfunction

    task automatic plan_scan(input logic [7:0] m);
        for (int c = 0; c < 8; c++) if (m[c]) exp_ch.push_back(c);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_busy(input logic val, input int budget, input string tag);
        int n = 0;
        while (busy !== val && n < budget) begin step(1); n++; end
        check(tag, 32'(busy), 32'(val));
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (exp_fifo.size() != 0 && n < budget) begin step(1); n++; end
        check(tag, 32'(exp_fifo.size()), 32'd0);
    endtask

    // SPI controller model: checks each command against scan order, answers after rsp_delay
    initial begin : responder
        bit          pending = 1'b0;
        bit          fired = 1'b0;
        bit          stray_done = 1'b0;
        int          cnt = 0;
        int          ch = 0;
        logic [23:0] w;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (fired) begin rsp_valid = 1'b0; fired = 1'b0; end
            if (stray_req != stray_done) begin
                stray_done = stray_req;
                rsp_data = 24'h0002AA;
                rsp_valid = 1'b1;
                fired = 1'b1;
            end
            if (cmd_valid) begin
                check("cmd_data", 32'(cmd_data),
                      exp_ch.size() != 0 ? 32'(cmd_word(exp_ch[0])) : 32'hFFFFFFFF);
                ch = (exp_ch.size() != 0) ? exp_ch.pop_front() : 0;
                if (hold) ;
                else if (ch == silent_ch) exp_fifo.push_back({3'(ch), 10'h3FF});
                else begin pending = 1'b1; cnt = rsp_delay; end
            end
            if (pending) begin
                if (cnt == 0) begin
                    w = (force_q.size() != 0) ? force_q.pop_front() : 24'($urandom);
                    rsp_data = w;
                    rsp_valid = 1'b1;
                    fired = 1'b1;
                    pending = 1'b0;
                    exp_fifo.push_back({3'(ch), w[9:0]});
                end else cnt--;
            end
        end
    end

    // Downstream model: drives m_ready per mode and checks every popped sample in order
    initial begin : consumer
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            m_ready = (ready_mode == 2) ? 1'($urandom) : (ready_mode == 1);
            #2;
            if (m_valid && m_ready) begin
                check("fifo_head", {19'b0, m_channel, m_data},
                      exp_fifo.size() != 0 ? {19'b0, exp_fifo[0]} : 32'h10000);
                if (exp_fifo.size() != 0) void'(exp_fifo.pop_front());
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int hi;
        logic [7:0] m;
        rst = 1'b1; enable = 1'b0; channel_mask = '0; clear_flags = 1'b0; cmd_ready = 1'b1;
        step(3);
        check("rst_cmd_valid", 32'(cmd_valid), 0);
        check("rst_cmd_data", 32'(cmd_data), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_m_channel", 32'(m_channel), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overflow", 32'(fifo_overflow), 0);
        check("rst_overrun", 32'(scan_overrun), 0);
        check("rst_timeout", 32'(rsp_timeout), 0);
        rst = 1'b0;

        // Directed scan of ch0/ch2 with fixed responses; exact tick and capture latency
        channel_mask = 8'b0000_0101;
        force_q.push_back(24'h0003FF);
        force_q.push_back(24'h000155);
        plan_scan(channel_mask);
        enable = 1'b1;
        step(P - 1);
        check("tick_not_early", 32'(busy), 0);
        step(1);
        check("tick_busy", 32'(busy), 1);
        hi = 0;
        while (!rsp_valid && hi < 20) begin step(1); hi++; end
        check("rsp_seen", 32'(rsp_valid), 1);
        step(1);
        check("m_valid_lat1", 32'(m_valid), 0);
        step(1);
        check("m_valid_lat2", 32'(m_valid), 1);
        check("first_sample", {19'b0, m_channel, m_data}, {19'b0, 3'd0, 10'h3FF});
        enable = 1'b0;
        wait_busy(1'b0, 100, "scan1_done");
        wait_drain(50, "scan1_drain");

        // Random masks, delays and downstream back-pressure; mask changed mid-scan
        ready_mode = 2;
        for (int it = 0; it < 4; it++) begin
            m = 8'($urandom_range(1, 255));
            channel_mask = m;
            plan_scan(m);
            rsp_delay = $urandom_range(0, 6);
            enable = 1'b1;
            wait_busy(1'b1, P + 5, "rand_start");
            channel_mask = 8'($urandom);
            enable = 1'b0;
            wait_busy(1'b0, 200, "rand_done");
            wait_drain(100, "rand_drain");
        end
        ready_mode = 1;
        rsp_delay = 0;

        // Slow response spans a tick: overrun flagged, tick dropped, next tick restarts
        channel_mask = 8'b0000_0001;
        plan_scan(channel_mask);
        plan_scan(channel_mask);
        rsp_delay = 150;
        enable = 1'b1;
        wait_busy(1'b1, P + 5, "ovr_start");
        step(3);
        rsp_delay = 0;
        wait_busy(1'b0, 300, "ovr_first_done");
        check("scan_overrun_set", 32'(scan_overrun), 1);
        step(10);
        check("tick_not_queued", 32'(busy), 0);
        wait_busy(1'b1, P, "ovr_restart");
        enable = 1'b0;
        wait_busy(1'b0, 50, "ovr_second_done");
        wait_drain(20, "ovr_drain");
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        check("scan_overrun_clr", 32'(scan_overrun), 0);

        // Two full scans with no draining: first 8 retained, rest dropped
        ready_mode = 0;
        channel_mask = 8'hFF;
        plan_scan(channel_mask);
        plan_scan(channel_mask);
        enable = 1'b1;
        wait_busy(1'b1, P + 5, "ovf_s1_start");
        wait_busy(1'b0, 100, "ovf_s1_done");
        wait_busy(1'b1, P + 5, "ovf_s2_start");
        enable = 1'b0;
        wait_busy(1'b0, 100, "ovf_s2_done");
        step(3);
        while (exp_fifo.size() > 8) void'(exp_fifo.pop_back());
        check("fifo_overflow_set", 32'(fifo_overflow), 1);
        check("fifo_full_valid", 32'(m_valid), 1);
        ready_mode = 1;
        step(8);
        check("drain_7_of_8", 32'(m_valid), 1);
        step(1);
        check("drain_8_of_8", 32'(m_valid), 0);
        check("drain_model", 32'(exp_fifo.size()), 0);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        check("fifo_overflow_clr", 32'(fifo_overflow), 0);

        // cmd_ready stall in ISSUE
        cmd_ready = 1'b0;
        channel_mask = 8'b0000_0010;
        plan_scan(channel_mask);
        enable = 1'b1;
        wait_busy(1'b1, P + 5, "stall_start");
        enable = 1'b0;
        hi = 0;
        repeat (50) begin step(1); if (cmd_valid) hi++; end
        check("stall_no_cmd", 32'(hi), 0);
        cmd_ready = 1'b1;
        step(1);
        check("cmd_after_ready", 32'(cmd_valid), 1);
        hi = 0;
        repeat (9) begin step(1); if (cmd_valid) hi++; end
        check("cmd_single_pulse", 32'(hi), 0);
        wait_busy(1'b0, 50, "stall_done");
        wait_drain(20, "stall_drain");

        // Reset while waiting for a response; stray response afterwards is ignored
        hold = 1'b1;
        channel_mask = 8'b0000_0001;
        plan_scan(channel_mask);
        enable = 1'b1;
        wait_busy(1'b1, P + 5, "rstmid_start");
        enable = 1'b0;
        step(4);
        check("rstmid_in_wait", 32'(busy), 1);
        rst = 1'b1;
        step(1);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_m_valid", 32'(m_valid), 0);
        rst = 1'b0;
        hold = 1'b0;
        stray_req = ~stray_req;
        step(6);
        check("stray_no_sample", 32'(m_valid), 0);
        check("stray_not_busy", 32'(busy), 0);

`ifdef ADC_SEQ_TIMEOUT_EN
        // Silent channel 3 times out with a 3FF sample, scan continues to channel 4
        silent_ch = 3;
        rsp_delay = 2;
        channel_mask = 8'b0001_1000;
        plan_scan(channel_mask);
        enable = 1'b1;
        wait_busy(1'b1, P + 5, "to_start");
        enable = 1'b0;
        wait_busy(1'b0, 200, "to_done");
        wait_drain(20, "to_drain");
        check("rsp_timeout_set", 32'(rsp_timeout), 1);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        check("rsp_timeout_clr", 32'(rsp_timeout), 0);
        silent_ch = -1;
`else
        check("rsp_timeout_tied", 32'(rsp_timeout), 0);
`endif

        check("model_cmds_left", 32'(exp_ch.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
